pc_fetch_seq: RTL

Sequential fetch controller that owns the program counter and drives the next-PC datapath for the multi-cycle CPU variant. It issues instruction-memory reads at the current PC, holds each fetched word for decode, and resolves branch, bne and jump redirects when decode accepts the word. It sits between instruction memory and the decode/execute stage and replaces the free-running PC update of the single-cycle core.

---
 rtl/pc_fetch_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_seq.sv
// -----------------------------------------------------------------------------
// pc_fetch_seq
//
// Sequential fetch controller for the multi-cycle CPU. It owns the program
// counter, issues instruction-memory reads at the PC, holds each fetched word
// for decode and computes the next PC (sequential, beq/bne branch, jump) when
// decode accepts the held word. A halt instruction parks the controller until
// reset.
//
// Optional feature: define PC_FETCH_SEQ_STATS_EN to build the retired/taken
// counters. Without it stat_retired and stat_taken are tied to 0.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   imem_req/addr    read request and address (address is the PC register)
//   imem_ack/rdata   read completion and instruction word
//   inst_valid/inst/inst_pc/inst_ready
//                    held instruction towards decode
//   branch, bne, zero, jump, offset, shamt, halt
//                    redirect information, sampled on accept only
//   halted           controller stopped on a halt
//   stat_retired     accepted-instruction count
//   stat_taken       taken-redirect count
//   state_dbg        current FSM state (IDLE=0, FETCH=1, HOLD=2, HALT=3)
//
// Handshakes: a memory read completes on a cycle with imem_req=1 and
// imem_ack=1 (imem_ack is ignored otherwise). An instruction transfers to
// decode on a cycle with inst_valid=1 and inst_ready=1 (accept); inst_ready
// without inst_valid has no effect. Both sides hold their outputs stable
// until the transfer happens.
// -----------------------------------------------------------------------------
module pc_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        branch,
  input  logic        bne,
  input  logic        zero,
  input  logic        jump,
  input  logic [25:0] offset,
  input  logic [31:0] shamt,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] stat_retired,
  output logic [31:0] stat_taken,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic        accept;
  logic        br_taken;
  logic [31:0] pc4;

  // Accept can only happen while an instruction is held.
  assign accept = (state_q == S_HOLD) && inst_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    pc4       = inst_pc_q + 32'd4;
    // With both branch and bne set exactly one of the two terms is true,
    // so the redirect is taken regardless of zero.
    br_taken  = (branch && zero) || (bne && !zero);

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          if (halt) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
            if (jump) begin
              pc_d = {pc4[31:28], offset, 2'b00};
            end else if (br_taken) begin
              // shamt counts words; the sum wraps modulo 2^32.
              pc_d = pc4 + {shamt[29:0], 2'b00};
            end else begin
              pc_d = pc4;
            end
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign halted     = (state_q == S_HALT);
  assign state_dbg  = state_q;

`ifdef PC_FETCH_SEQ_STATS_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] taken_q, taken_d;
  logic        redirect_taken;

  // A halt is retired but never counts as a taken redirect.
  assign redirect_taken = !halt && (jump || br_taken);

  always_comb begin
    retired_d = retired_q;
    taken_d   = taken_q;
    if (accept) begin
      retired_d = retired_q + 32'd1;
      if (redirect_taken) begin
        taken_d = taken_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
      taken_q   <= 32'd0;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign stat_retired = retired_q;
  assign stat_taken   = taken_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign stat_retired  = 32'd0;
  assign stat_taken    = 32'd0;
`endif

endmodule
